// File: rtl/sample_buffer_server.sv
// Capture-side responder for the sample-buffer read handshake: fills a frame of DEPTH
// samples, offers it to a single reader, streams it out one sample per ack, then refills.
module sample_buffer_server #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int DEPTH          = 256,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [SAMPLE_WIDTH-1:0]      sample_i,
    input  logic                         sample_valid_i,
    output logic                         buffer_ready_o,
    output logic                         read_enable_o,
    output logic [SAMPLE_WIDTH-1:0]      ram_sample_o,
    input  logic                         read_ack_i,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level_o,
    output logic [DROP_CNT_WIDTH-1:0]    drop_cnt_o,
    output logic                         frame_done_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_OFFER,
        ST_STREAM
    } state_e;

    state_e                      state_q;
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [FW-1:0]               fill_q;
    logic                        ready_q;
    logic                        rd_en_q;
    logic [SAMPLE_WIDTH-1:0]     sample_q;
    logic [DROP_CNT_WIDTH-1:0]   drop_q;
    logic                        done_q;

    logic [SAMPLE_WIDTH-1:0]     mem [DEPTH];

    logic                        wr_en;
    logic                        consume;
    logic [AW-1:0]               rd_addr_d;

    assign wr_en   = (state_q == ST_FILL) && sample_valid_i;
    assign consume = read_ack_i && rd_en_q;

    // While filling, the read port prefetches mem[0] so the offer cycle has it ready.
    always_comb begin
        rd_addr_d = rd_ptr_q;
        if (state_q == ST_FILL) begin
            rd_addr_d = '0;
        end else if (consume) begin
            rd_addr_d = rd_ptr_q + AW'(1);
        end
    end

    // NOTE: the sample RAM has no reset so it maps onto block RAM; stale contents are
    // never visible because every frame is fully rewritten before it is offered.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ready_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            sample_q <= '0;
            drop_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if ((state_q != ST_FILL) && sample_valid_i && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_CNT_WIDTH'(1);
            end

            unique case (state_q)
                ST_FILL: begin
                    if (sample_valid_i) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        fill_q   <= fill_q + FW'(1);
                        if (wr_ptr_q == LAST_IDX) begin
                            state_q  <= ST_OFFER;
                            ready_q  <= 1'b1;
                            rd_en_q  <= 1'b1;
                            rd_ptr_q <= '0;
                            sample_q <= mem[rd_addr_d];
                        end
                    end
                end

                ST_OFFER: begin
                    // DEPTH >= 2, so the first consumption is never the last one.
                    if (consume) begin
                        state_q  <= ST_STREAM;
                        ready_q  <= 1'b0;
                        rd_ptr_q <= rd_addr_d;
                        sample_q <= mem[rd_addr_d];
                    end
                end

                ST_STREAM: begin
                    if (consume) begin
                        if (rd_ptr_q == LAST_IDX) begin
                            state_q  <= ST_FILL;
                            rd_en_q  <= 1'b0;
                            done_q   <= 1'b1;
                            rd_ptr_q <= '0;
                            wr_ptr_q <= '0;
                            fill_q   <= '0;
                        end else begin
                            rd_ptr_q <= rd_addr_d;
                            sample_q <= mem[rd_addr_d];
                        end
                    end
                end

                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign buffer_ready_o = ready_q;
    assign read_enable_o  = rd_en_q;
    assign ram_sample_o   = sample_q;
    assign fill_level_o   = fill_q;
    assign drop_cnt_o     = drop_q;
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_sample_buffer_server.sv
// Bench for sample_buffer_server: directed handshake scenarios plus random traffic, all
// checked each cycle against a frame-level reference model.
module tb_sample_buffer_server;

    localparam int DEPTH = 4;
    localparam int SW    = 16;
    localparam int DW    = 16;
    localparam int DW2   = 2;
    localparam int FW    = $clog2(DEPTH + 1);

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [SW-1:0]   sample_i = '0;
    logic            sample_valid_i = 1'b0;
    logic            read_ack_i = 1'b0;
    logic            buffer_ready_o, read_enable_o, frame_done_o;
    logic [SW-1:0]   ram_sample_o;
    logic [FW-1:0]   fill_level_o;
    logic [DW-1:0]   drop_cnt_o;
    logic            ready_b, enable_b, done_b;
    logic [SW-1:0]   sample_b;
    logic [FW-1:0]   fill_b;
    logic [DW2-1:0]  drop_cnt_b;

    sample_buffer_server #(.SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .buffer_ready_o(buffer_ready_o), .read_enable_o(read_enable_o),
        .ram_sample_o(ram_sample_o), .read_ack_i(read_ack_i), .fill_level_o(fill_level_o),
        .drop_cnt_o(drop_cnt_o), .frame_done_o(frame_done_o)
    );

    // Narrow drop counter instance, used to observe saturation.
    sample_buffer_server #(.SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DW2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .buffer_ready_o(ready_b), .read_enable_o(enable_b),
        .ram_sample_o(sample_b), .read_ack_i(read_ack_i), .fill_level_o(fill_b),
        .drop_cnt_o(drop_cnt_b), .frame_done_o(done_b)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: frame contents as a queue, reader position as an index.
    logic [SW-1:0] m_frame[$];
    bit            m_reading, m_acked, m_done;
    int            m_idx, m_drops;
    logic [SW-1:0] m_sample;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] rnd();
        return SW'($urandom);
    endfunction

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_frame.delete();
        m_reading = 0;
        m_acked   = 0;
        m_done    = 0;
        m_idx     = 0;
        m_drops   = 0;
        m_sample  = '0;
    endtask

    task automatic model_clock(input bit v, input logic [SW-1:0] s, input bit a);
        m_done = 0;
        if (!m_reading) begin
            if (v) begin
                m_frame.push_back(s);
                if (m_frame.size() == DEPTH) begin
                    m_reading = 1;
                    m_acked   = 0;
                    m_idx     = 0;
                    m_sample  = m_frame[0];
                end
            end
        end else begin
            if (v) m_drops++;
            if (a) begin
                m_acked = 1;
                if (m_idx == DEPTH - 1) begin
                    m_reading = 0;
                    m_done    = 1;
                    m_frame.delete();
                end else begin
                    m_idx++;
                    m_sample = m_frame[m_idx];
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("buffer_ready", 32'(buffer_ready_o), 32'(m_reading && !m_acked));
        check("read_enable",  32'(read_enable_o),  32'(m_reading));
        if (m_reading) check("ram_sample", 32'(ram_sample_o), 32'(m_sample));
        check("fill_level",   32'(fill_level_o),   m_reading ? DEPTH : m_frame.size());
        check("drop_cnt",     32'(drop_cnt_o),     sat(m_drops, DW));
        check("drop_cnt_sat", 32'(drop_cnt_b),     sat(m_drops, DW2));
        check("frame_done",   32'(frame_done_o),   32'(m_done));
    endtask

    task automatic step(input bit v, input logic [SW-1:0] s, input bit a);
        sample_valid_i = v;
        sample_i       = s;
        read_ack_i     = a;
        @(posedge clk_i);
        model_clock(v, s, a);
        #1;
        check_outputs();
    endtask

    initial begin
        int bound;
        model_reset();
        #12;
        check("rst_ready",  32'(buffer_ready_o), 0);
        check("rst_enable", 32'(read_enable_o),  0);
        check("rst_sample", 32'(ram_sample_o),   0);
        check("rst_fill",   32'(fill_level_o),   0);
        check("rst_drop",   32'(drop_cnt_o),     0);
        check("rst_done",   32'(frame_done_o),   0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Frame 1: boundary sample values, reader acks one cycle after ready, then continuously.
        step(1, 16'h0001, 0);
        step(1, 16'hFFFF, 0);
        step(1, 16'h8000, 0);
        step(1, 16'h7FFF, 0);
        check("offer_sample", 32'(ram_sample_o), 32'h0001);
        check("offer_fill",   32'(fill_level_o), DEPTH);
        step(0, '0, 0);
        step(0, '0, 1);
        check("second_sample", 32'(ram_sample_o), 32'hFFFF);
        step(0, '0, 1);
        check("third_sample", 32'(ram_sample_o), 32'h8000);
        step(0, '0, 1);
        check("fourth_sample", 32'(ram_sample_o), 32'h7FFF);
        step(0, '0, 1);
        check("end_enable", 32'(read_enable_o), 0);
        check("end_done",   32'(frame_done_o),  1);
        step(0, '0, 1);
        check("trailing_ack_fill", 32'(fill_level_o), 0);

        // Frame 2: stall three cycles after sample 1 with five drops along the way.
        for (int i = 0; i < DEPTH; i++) step(1, rnd(), 0);
        step(1, rnd(), 0);
        step(1, rnd(), 1);
        step(1, rnd(), 0);
        step(1, rnd(), 0);
        step(0, '0, 0);
        step(1, rnd(), 1);
        step(0, '0, 1);
        step(0, '0, 1);
        check("drops_five", 32'(drop_cnt_o), 5);
        check("drops_sat",  32'(drop_cnt_b), 3);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < DEPTH; i++) step(1, rnd(), 0);
        step(0, '0, 1);
        step(0, '0, 1);
        #3;
        rst_i = 1'b1;
        #1;
        model_reset();
        check("arst_ready",  32'(buffer_ready_o), 0);
        check("arst_enable", 32'(read_enable_o),  0);
        check("arst_sample", 32'(ram_sample_o),   0);
        check("arst_fill",   32'(fill_level_o),   0);
        check("arst_drop",   32'(drop_cnt_o),     0);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) step(1, rnd(), 0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1);

        // Back-to-back frames with valid and ack held high throughout.
        for (int i = 0; i < 30; i++) step(1, rnd(), 1);

        // Random traffic.
        for (int i = 0; i < 500; i++) step(bit'($urandom_range(0, 1)), rnd(), bit'($urandom_range(0, 1)));

        // Random reset landing mid-stream, with a bounded search for the stream state.
        bound = 0;
        while (!(m_reading && m_acked) && bound < 50) begin
            step(1, rnd(), bit'($urandom_range(0, 1)));
            bound++;
        end
        check("reach_stream", 32'(m_reading && m_acked), 1);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 100; i++) step(bit'($urandom_range(0, 1)), rnd(), bit'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
